// File: rtl/cla_seq_ctrl.sv
// cla_seq_ctrl: byte-serial add/subtract controller built around one 8-bit
// carry-lookahead adder. Operands are latched on acceptance, then processed
// LSB byte first over NBYTES cycles; the result is held until taken.
// Optional feature: define CLA_SEQ_OVF_EN to add out_ovf (signed overflow).
module cla_seq_ctrl #(
  parameter int NBYTES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [8*NBYTES-1:0] in_a,
  input  logic [8*NBYTES-1:0] in_b,
  input  logic                in_sub,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [8*NBYTES-1:0] out_sum,
  output logic                out_cout,
  output logic                busy
`ifdef CLA_SEQ_OVF_EN
  ,
  output logic                out_ovf
`endif
);

  localparam int W = 8 * NBYTES;
  localparam logic [2:0] LAST = 3'(NBYTES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t       r_state;
  logic [W-1:0] r_a;
  logic [W-1:0] r_b;
  logic [W-1:0] r_sum;
  logic [2:0]   r_idx;
  logic         r_carry;
  logic         r_cout;
  logic         r_valid;
  logic         r_ready;
  logic         r_busy;

  logic [7:0]   w_ba;
  logic [7:0]   w_bb;
  logic [7:0]   w_g;
  logic [7:0]   w_p;
  logic [7:0]   w_s;
  logic [8:0]   w_c;
  logic [5:0]   w_base;

  assign w_base = {r_idx, 3'b000};

  // Current byte of each operand, selected by the byte index.
  always_comb begin
    w_ba = 8'(r_a >> w_base);
    w_bb = 8'(r_b >> w_base);
  end

  // 8-bit carry-lookahead: each carry is the sum-of-products of generate
  // terms gated by the propagate chain below it, plus the propagated carry-in.
  always_comb begin
    logic v_gen;
    logic v_prop;
    w_g    = w_ba & w_bb;
    w_p    = w_ba ^ w_bb;
    w_c    = '0;
    w_c[0] = r_carry;
    v_gen  = 1'b0;
    v_prop = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      v_gen  = w_g[i];
      v_prop = w_p[i];
      for (int unsigned j = 0; j < i; j++) begin
        v_gen  = v_gen | (v_prop & w_g[i-1-j]);
        v_prop = v_prop & w_p[i-1-j];
      end
      w_c[i+1] = v_gen | (v_prop & r_carry);
    end
    w_s = w_p ^ w_c[7:0];
  end

`ifdef CLA_SEQ_OVF_EN
  logic r_ovf;

  // Signed overflow captured from the MSB carries of the final byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (r_state == RUN && r_idx == LAST) begin
      r_ovf <= w_c[7] ^ w_c[8];
    end
  end

  assign out_ovf = r_ovf;
`endif

  // Sequencer FSM: accept in IDLE, one byte per cycle in RUN, hold in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_valid <= 1'b0;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a     <= in_a;
            r_b     <= in_sub ? ~in_b : in_b;
            r_idx   <= '0;
            r_carry <= in_sub;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_sum[w_base +: 8] <= w_s;
          r_carry            <= w_c[8];
          r_idx              <= r_idx + 3'd1;
          if (r_idx == LAST) begin
            r_cout  <= w_c[8];
            r_valid <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_valid <= 1'b0;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_ready;
  assign out_valid = r_valid;
  assign out_sum   = r_sum;
  assign out_cout  = r_cout;
  assign busy      = r_busy;

endmodule

// File: tb/tb_cla_seq_ctrl.sv
// Randomized self-checking bench for cla_seq_ctrl against a plain-arithmetic
// reference of add/subtract with carry-out and signed overflow.
module tb_cla_seq_ctrl;

  localparam int NB = 4;
  localparam int W  = 8 * NB;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         busy;
`ifdef CLA_SEQ_OVF_EN
  logic         out_ovf;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  cla_seq_ctrl #(.NBYTES(NB)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .busy      (busy)
`ifdef CLA_SEQ_OVF_EN
    ,
    .out_ovf   (out_ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // One full transaction: present, accept, measure latency, compare against
  // the arithmetic reference, stall with junk on the inputs, then release.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sub, input int stall);
    logic [W-1:0] bb;
    logic [W:0]   full;
    logic         exp_ovf;
    int           lat;
    bb      = sub ? ~b : b;
    full    = {1'b0, a} + {1'b0, bb} + (W+1)'(sub);
    exp_ovf = (a[W-1] == bb[W-1]) && (full[W-1] != a[W-1]);

    check("ready_idle", 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_sub   = sub;
    @(posedge clk);
    #1;
    // Scramble inputs after acceptance; they must have no effect.
    lat = 0;
    while (!out_valid && lat < 20) begin
      in_valid = 1'($urandom);
      in_a     = W'($urandom);
      in_b     = W'($urandom);
      in_sub   = 1'($urandom);
      if (lat == 0) check("busy_run", 64'(busy), 64'd1);
      @(posedge clk);
      lat++;
      #1;
    end
    check("latency", 64'(lat), 64'(NB));
    check("sum", 64'(out_sum), 64'(full[W-1:0]));
    check("cout", 64'(out_cout), 64'(full[W]));
`ifdef CLA_SEQ_OVF_EN
    check("ovf", 64'(out_ovf), 64'(exp_ovf));
`endif
    check("busy_done", 64'(busy), 64'd1);

    for (int s = 0; s < stall; s++) begin
      in_valid = 1'($urandom);
      in_a     = W'($urandom);
      @(posedge clk);
      #1;
      check("stall_valid", 64'(out_valid), 64'd1);
      check("stall_ready", 64'(in_ready), 64'd0);
      check("stall_sum", 64'(out_sum), 64'(full[W-1:0]));
      check("stall_cout", 64'(out_cout), 64'(full[W]));
`ifdef CLA_SEQ_OVF_EN
      check("stall_ovf", 64'(out_ovf), 64'(exp_ovf));
`endif
    end

    out_ready = 1'b1;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("rel_valid", 64'(out_valid), 64'd0);
    check("rel_ready", 64'(in_ready), 64'd1);
    check("rel_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_sub    = 1'b0;
    out_ready = 1'b0;
    #12;
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_ready", 64'(in_ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_sum", 64'(out_sum), 64'd0);
    check("rst_cout", 64'(out_cout), 64'd0);
`ifdef CLA_SEQ_OVF_EN
    check("rst_ovf", 64'(out_ovf), 64'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Directed corner cases.
    run_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 0);
    run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1);
    run_op(32'h0000_0005, 32'h0000_0007, 1'b1, 0);
    run_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1, 0);
    run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 0);
    run_op(32'h8000_0000, 32'h0000_0001, 1'b1, 0);
    // Long backpressure with input toggling.
    run_op(32'h1234_5678, 32'h0FED_CBA9, 1'b0, 10);

    // Abort mid-operation.
    in_valid = 1'b1;
    in_a     = 32'hDEAD_BEEF;
    in_b     = 32'h0101_0101;
    in_sub   = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_valid", 64'(out_valid), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_sum", 64'(out_sum), 64'd0);
    check("abort_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(32'h0000_0001, 32'h0000_0002, 1'b0, 0);

    // Random traffic with random stalls.
    for (int n = 0; n < 100; n++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      case ($urandom_range(0, 7))
        0: ra = '1;
        1: rb = '0;
        2: rb = '1;
        default: ;
      endcase
      run_op(ra, rb, 1'($urandom), int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
